// File: rtl/com_sprom_rr_arb.sv
// Round-robin arbiter and read sequencer sharing one single-port ROM (1-cycle latency)
// among REQ_N requesters, with a credit-checked in-order response FIFO.

`ifndef COM_SYS_W
`define COM_SYS_W 16
`endif

module com_sprom_rr_arb #(
  parameter int unsigned REQ_N     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned RSP_DEPTH = 2,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [`COM_SYS_W-1:0]   sys_cfg,
  input  logic [REQ_N-1:0]        req_vld,
  input  logic [REQ_N*ADDR_W-1:0] req_addr,
  output logic [REQ_N-1:0]        req_rdy,
  output logic [REQ_N-1:0]        rsp_vld,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic [REQ_N-1:0]        rsp_rdy,
  output logic                    busy,
  output logic                    rom_rd_en,
  output logic [ADDR_W-1:0]       rom_rd_addr,
  input  logic [DATA_W-1:0]       rom_rd_data,
  output logic [`COM_SYS_W-1:0]   rom_sys_cfg
);

  localparam int unsigned REQ_W  = $clog2(REQ_N);
  localparam int unsigned FIDX_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

  logic [REQ_W-1:0]  rr_ptr;
  logic              inflight;
  logic [REQ_W-1:0]  inflight_owner;
  logic              inflight_oor;

  logic [REQ_W-1:0]  fifo_owner [RSP_DEPTH];
  logic [DATA_W-1:0] fifo_data  [RSP_DEPTH];
  logic [FIDX_W-1:0] rd_idx;
  logic [FIDX_W-1:0] wr_idx;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              head_vld;
  logic [REQ_W-1:0]  head_owner;
  logic              pop;
  logic              push;
  logic              credit_ok;
  logic              gnt_found;
  logic              gnt_vld;
  logic [REQ_W-1:0]  gnt_idx;
  logic [REQ_W-1:0]  cand;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oor;

  function automatic logic [FIDX_W-1:0] idx_next(input logic [FIDX_W-1:0] idx);
    return (32'(idx) == RSP_DEPTH - 1) ? '0 : idx + FIDX_W'(1);
  endfunction

  assign head_vld   = (fifo_cnt != '0);
  assign head_owner = fifo_owner[rd_idx];
  assign pop        = head_vld & rsp_rdy[head_owner];
  assign push       = inflight;

  // A grant needs a FIFO slot for its data after the in-flight read and any pop this cycle.
  assign credit_ok = (32'(fifo_cnt) + 32'(inflight)) < (RSP_DEPTH + 32'(pop));

  // Round-robin search starting just above the last winner, wrapping at REQ_N.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= REQ_N; i++) begin
      cand = REQ_W'((32'(rr_ptr) + i) % REQ_N);
      if (!gnt_found && req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign sel_addr = req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];
  assign sel_oor  = (32'(sel_addr) >= DEPTH);
  assign gnt_vld  = rst_n & gnt_found & credit_ok;

  always_comb begin
    req_rdy     = '0;
    rom_rd_en   = 1'b0;
    rom_rd_addr = '0;
    if (gnt_vld) begin
      req_rdy[gnt_idx] = 1'b1;
      rom_rd_en        = ~sel_oor;
      rom_rd_addr      = sel_addr;
    end
  end

  always_comb begin
    rsp_vld  = '0;
    rsp_data = '0;
    if (head_vld) begin
      rsp_vld[head_owner] = 1'b1;
      rsp_data            = fifo_data[rd_idx];
    end
  end

  assign busy        = inflight | head_vld;
  assign rom_sys_cfg = sys_cfg;

  // Grant pointer and the single read-in-flight stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= REQ_W'(REQ_N - 1);
      inflight       <= 1'b0;
      inflight_owner <= '0;
      inflight_oor   <= 1'b0;
    end else begin
      inflight <= gnt_vld;
      if (gnt_vld) begin
        rr_ptr         <= gnt_idx;
        inflight_owner <= gnt_idx;
        inflight_oor   <= sel_oor;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= '0;
      wr_idx   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_owner[i] <= '0;
        fifo_data[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_owner[wr_idx] <= inflight_owner;
        fifo_data[wr_idx]  <= inflight_oor ? '0 : rom_rd_data;
        wr_idx             <= idx_next(wr_idx);
      end
      if (pop) begin
        rd_idx <= idx_next(rd_idx);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (32'(fifo_cnt) == RSP_DEPTH)));

endmodule

// File: tb/tb_com_sprom_rr_arb.sv
// Bench for com_sprom_rr_arb: directed vector table, hand sequences for multi-cycle
// corner cases, then randomized traffic against a queue-based reference model.

`ifndef COM_SYS_W
`define COM_SYS_W 16
`endif

module tb_com_sprom_rr_arb;

  localparam int unsigned REQ_N  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 48;
  localparam int unsigned RSPD   = 2;
  localparam int unsigned ADDR_W = 6;

  logic                    clk;
  logic                    rst_n;
  logic [`COM_SYS_W-1:0]   sys_cfg;
  logic [REQ_N-1:0]        req_vld;
  logic [REQ_N*ADDR_W-1:0] req_addr;
  logic [REQ_N-1:0]        req_rdy;
  logic [REQ_N-1:0]        rsp_vld;
  logic [DATA_W-1:0]       rsp_data;
  logic [REQ_N-1:0]        rsp_rdy;
  logic                    busy;
  logic                    rom_rd_en;
  logic [ADDR_W-1:0]       rom_rd_addr;
  logic [DATA_W-1:0]       rom_rd_data;
  logic [`COM_SYS_W-1:0]   rom_sys_cfg;

  com_sprom_rr_arb #(
    .REQ_N(REQ_N), .DATA_W(DATA_W), .DEPTH(DEPTH), .RSP_DEPTH(RSPD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sys_cfg(sys_cfg),
    .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
    .busy(busy), .rom_rd_en(rom_rd_en), .rom_rd_addr(rom_rd_addr),
    .rom_rd_data(rom_rd_data), .rom_sys_cfg(rom_sys_cfg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] romf(input logic [5:0] a);
    return 32'hC0DE_5A5A ^ {a, a, a, a, 8'h00};
  endfunction

  // ROM model: 1-cycle latency, garbage when not enabled.
  always @(posedge clk) begin
    rom_rd_data <= rom_en_val(rom_rd_en, rom_rd_addr);
  end

  function automatic logic [31:0] rom_en_val(input logic en, input logic [5:0] a);
    return en ? romf(a) : $urandom();
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_rdy, input logic e_en,
                         input logic [5:0] e_addr, input logic [3:0] e_rsp,
                         input logic [31:0] e_data, input logic e_busy);
    chk({tag, ".req_rdy"}, 32'(req_rdy), 32'(e_rdy));
    chk({tag, ".rom_rd_en"}, 32'(rom_rd_en), 32'(e_en));
    chk({tag, ".rom_rd_addr"}, 32'(rom_rd_addr), 32'(e_addr));
    chk({tag, ".rsp_vld"}, 32'(rsp_vld), 32'(e_rsp));
    chk({tag, ".rsp_data"}, rsp_data, e_data);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [23:0] addr;
    logic [3:0]  rrdy;
    logic [3:0]  e_rdy;
    logic        e_en;
    logic [5:0]  e_addr;
    logic [3:0]  e_rsp;
    logic [31:0] e_data;
    logic        e_busy;
  } vec_t;

  vec_t tbl[17];

  typedef struct {
    int          owner;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        pend;
  bit          pend_v;
  int          mptr;
  logic [5:0]  cur_addr[4];
  logic [3:0]  cur_vld;
  logic [3:0]  m_gnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] aa, a1, a2;
    logic [31:0] exp_q[$];
    int          gcount, got;
    logic [5:0]  a;
    logic [3:0]  rst_exp[4];

    aa = {6'd47, 6'd33, 6'd17, 6'd5};
    a1 = {6'd0, 6'd0, 6'd5, 6'd0};
    a2 = {6'd0, 6'd50, 6'd0, 6'd0};
    tbl[0]  = '{4'hF, aa, 4'hF, 4'b0001, 1'b1, 6'd5,  4'b0000, 32'h0,       1'b0};
    tbl[1]  = '{4'hF, aa, 4'hF, 4'b0010, 1'b1, 6'd17, 4'b0000, 32'h0,       1'b1};
    tbl[2]  = '{4'hF, aa, 4'hF, 4'b0100, 1'b1, 6'd33, 4'b0001, romf(6'd5),  1'b1};
    tbl[3]  = '{4'hF, aa, 4'hF, 4'b1000, 1'b1, 6'd47, 4'b0010, romf(6'd17), 1'b1};
    tbl[4]  = '{4'hF, aa, 4'hF, 4'b0001, 1'b1, 6'd5,  4'b0100, romf(6'd33), 1'b1};
    tbl[5]  = '{4'hF, aa, 4'hF, 4'b0010, 1'b1, 6'd17, 4'b1000, romf(6'd47), 1'b1};
    tbl[6]  = '{4'h0, aa, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0001, romf(6'd5),  1'b1};
    tbl[7]  = '{4'h0, aa, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0010, romf(6'd17), 1'b1};
    tbl[8]  = '{4'h0, aa, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0000, 32'h0,       1'b0};
    tbl[9]  = '{4'h2, a1, 4'hF, 4'b0010, 1'b1, 6'd5,  4'b0000, 32'h0,       1'b0};
    tbl[10] = '{4'h0, a1, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0000, 32'h0,       1'b1};
    tbl[11] = '{4'h0, a1, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0010, romf(6'd5),  1'b1};
    tbl[12] = '{4'h0, a1, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0000, 32'h0,       1'b0};
    tbl[13] = '{4'h4, a2, 4'hF, 4'b0100, 1'b0, 6'd50, 4'b0000, 32'h0,       1'b0};
    tbl[14] = '{4'h0, a2, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0000, 32'h0,       1'b1};
    tbl[15] = '{4'h0, a2, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0100, 32'h0,       1'b1};
    tbl[16] = '{4'h0, a2, 4'hF, 4'b0000, 1'b0, 6'd0,  4'b0000, 32'h0,       1'b0};

    // Reset state, with requests pending to show grants are held off.
    rst_n    = 1'b0;
    req_vld  = 4'hF;
    req_addr = aa;
    rsp_rdy  = 4'hF;
    sys_cfg  = `COM_SYS_W'(16'hA5C3);
    repeat (2) @(posedge clk);
    #3;
    chk_all("reset", 4'b0, 1'b0, 6'd0, 4'b0, 32'h0, 1'b0);
    chk("reset.sys_cfg", 32'(rom_sys_cfg), 32'(sys_cfg));
    req_vld = 4'h0;
    tick();
    rst_n = 1'b1;

    // Directed vectors: full rotation, single request, out-of-range address.
    for (int r = 0; r < 17; r++) begin
      req_vld  = tbl[r].vld;
      req_addr = tbl[r].addr;
      rsp_rdy  = tbl[r].rrdy;
      #4;
      chk_all($sformatf("vec%0d", r), tbl[r].e_rdy, tbl[r].e_en, tbl[r].e_addr,
              tbl[r].e_rsp, tbl[r].e_data, tbl[r].e_busy);
      tick();
    end

    // Backpressure: requester 0 streams with its response channel stalled.
    rsp_rdy = 4'h0;
    gcount  = 0;
    a       = 6'd10;
    for (int k = 0; k < 8; k++) begin
      req_vld  = 4'b0001;
      req_addr = {18'd0, a};
      #4;
      if (req_rdy != 4'b0000) chk("bp.onehot", 32'(req_rdy), 32'(4'b0001));
      if (req_rdy[0]) begin
        exp_q.push_back(romf(a));
        gcount++;
        a = a + 6'd1;
      end
      tick();
    end
    chk("bp.grants", 32'(gcount), 32'(RSPD));
    req_vld = 4'h0;
    rsp_rdy = 4'b0001;
    got     = 0;
    for (int k = 0; k < 8; k++) begin
      #4;
      if (rsp_vld != 4'b0000) begin
        chk("bp.rsp_vld", 32'(rsp_vld), 32'(4'b0001));
        if (exp_q.size() == 0) chk("bp.extra_rsp", 32'(got + 1), 32'(RSPD));
        else chk("bp.rsp_data", rsp_data, exp_q.pop_front());
        got++;
      end
      tick();
    end
    chk("bp.rsp_count", 32'(got), 32'(RSPD));

    // Head-of-line: owner 1 stalled blocks requester 2's queued response.
    rsp_rdy  = 4'b0100;
    req_vld  = 4'b0010;
    req_addr = {6'd0, 6'd9, 6'd7, 6'd0};
    #4;
    chk("hol.gnt1", 32'(req_rdy), 32'(4'b0010));
    tick();
    req_vld = 4'b0100;
    #4;
    chk("hol.gnt2", 32'(req_rdy), 32'(4'b0100));
    tick();
    req_vld = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk("hol.stall_vld", 32'(rsp_vld), 32'(4'b0010));
      chk("hol.stall_data", rsp_data, romf(6'd7));
      tick();
    end
    rsp_rdy = 4'b0110;
    #4;
    chk("hol.rel_vld", 32'(rsp_vld), 32'(4'b0010));
    tick();
    #4;
    chk("hol.next_vld", 32'(rsp_vld), 32'(4'b0100));
    chk("hol.next_data", rsp_data, romf(6'd9));
    tick();
    #4;
    chk("hol.empty", 32'(rsp_vld), 32'(4'b0000));
    tick();

    // Reset with two reads outstanding.
    rsp_rdy  = 4'hF;
    req_addr = {6'd0, 6'd0, 6'd4, 6'd3};
    req_vld  = 4'b0001;
    #4;
    chk("rst.gnt0", 32'(req_rdy), 32'(4'b0001));
    tick();
    req_vld = 4'b0010;
    #4;
    chk("rst.gnt1", 32'(req_rdy), 32'(4'b0010));
    tick();
    req_vld = 4'hF;
    #2;
    chk("rst.busy_before", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 4'b0, 1'b0, 6'd0, 4'b0, 32'h0, 1'b0);
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    #4;
    chk("rst.first_gnt", 32'(req_rdy), 32'(4'b0001));
    chk("rst.first_addr", 32'(rom_rd_addr), 32'(6'd3));
    chk("rst.no_stale", 32'(rsp_vld), 32'(4'b0000));
    tick();
    req_vld    = 4'h0;
    rst_exp[0] = 4'b0000;
    rst_exp[1] = 4'b0001;
    rst_exp[2] = 4'b0000;
    rst_exp[3] = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk($sformatf("rst.post%0d", k), 32'(rsp_vld), 32'(rst_exp[k]));
      if (rst_exp[k] != 4'b0) chk("rst.post_data", rsp_data, romf(6'd3));
      tick();
    end

    // Randomized traffic against the queue-based reference model.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    mq.delete();
    pend_v  = 1'b0;
    mptr    = REQ_N - 1;
    cur_vld = 4'h0;
    m_gnt   = 4'h0;
    for (int i = 0; i < 4; i++) cur_addr[i] = 6'd0;
    for (int c = 0; c < 3000; c++) begin
      int          g;
      bit          m_pop;
      bit          credit;
      logic [3:0]  e_rsp;
      logic [31:0] e_data;
      for (int i = 0; i < 4; i++) begin
        if (cur_vld[i] && !m_gnt[i]) begin
          if ($urandom_range(0, 9) == 0) cur_vld[i] = 1'b0;
        end else begin
          cur_vld[i]  = 1'($urandom_range(0, 1));
          cur_addr[i] = 6'($urandom_range(0, 63));
        end
        rsp_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      req_vld  = cur_vld;
      req_addr = {cur_addr[3], cur_addr[2], cur_addr[1], cur_addr[0]};
      sys_cfg  = `COM_SYS_W'($urandom());
      #4;
      m_pop  = (mq.size() > 0) && rsp_rdy[mq[0].owner];
      credit = (mq.size() + int'(pend_v) - int'(m_pop)) < RSPD;
      g = -1;
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (mptr + k) % 4;
        if (g < 0 && req_vld[j]) g = j;
      end
      if (!credit) g = -1;
      m_gnt  = (g >= 0) ? 4'(1 << g) : 4'h0;
      e_rsp  = (mq.size() > 0) ? 4'(1 << mq[0].owner) : 4'h0;
      e_data = (mq.size() > 0) ? mq[0].data : 32'h0;
      chk_all("rand", m_gnt, (g >= 0) && (cur_addr[(g >= 0) ? g : 0] < DEPTH),
              (g >= 0) ? cur_addr[g] : 6'd0, e_rsp, e_data, pend_v || (mq.size() > 0));
      chk("rand.sys_cfg", 32'(rom_sys_cfg), 32'(sys_cfg));
      if (m_pop) void'(mq.pop_front());
      if (pend_v) mq.push_back(pend);
      pend_v = (g >= 0);
      if (g >= 0) begin
        pend.owner = g;
        pend.data  = (cur_addr[g] < DEPTH) ? romf(cur_addr[g]) : 32'h0;
        mptr       = g;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
